// File: rtl/jk_cmd_arbiter_if.sv
// Requester and JK-bank signal bundle for jk_cmd_arbiter.
// The master side is the request sources plus the bank; the slave side is the arbiter.
interface jk_cmd_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [NBITS*NREQ-1:0] req_mask;
  logic [NBITS-1:0]      J;
  logic [NBITS-1:0]      K;
  logic [NBITS-1:0]      q_in;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [NBITS-1:0]      rd_data;
  logic                  err;

  modport master (
    output req_valid, req_op, req_mask, q_in,
    input  req_ready, J, K, done, done_id, rd_data, err
  );

  modport slave (
    input  req_valid, req_op, req_mask, q_in,
    output req_ready, J, K, done, done_id, rd_data, err
  );
endinterface

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that shares one JK flip-flop bank, one command per 4 cycles.
// Optional post-command readback check enabled by defining JK_CMD_VERIFY_EN.
module jk_cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  jk_cmd_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, winner, id_q;
  logic             found;
  logic [1:0]       win_op;
  logic [NBITS-1:0] win_mask;
  logic [NBITS-1:0] j_q, k_q, rd_q;
  logic [SW-1:0]    scan;
  logic [IDW-1:0]   scan_idx;

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan     = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + SW'(k);
      if (scan >= SW'(NREQ))
        scan = scan - SW'(NREQ);
      scan_idx = scan[IDW-1:0];
      if (!found && bus.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    win_op   = '0;
    win_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == winner) begin
        win_op   = bus.req_op[2*i +: 2];
        win_mask = bus.req_mask[NBITS*i +: NBITS];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      bus.req_ready[i] = (state == IDLE) && found && !reset && (IDW'(i) == winner);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // J/K are loaded at the grant edge so the bank sees them for exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      j_q    <= '0;
      k_q    <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_nxt;
      j_q   <= '0;
      k_q   <= '0;
      if (state == IDLE && found) begin
        id_q   <= winner;
        j_q    <= win_mask & {NBITS{win_op[1]}};
        k_q    <= win_mask & {NBITS{win_op[0]}};
        rr_ptr <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
      end
      if (state == CAPTURE)
        rd_q <= bus.q_in;
    end
  end

  assign bus.J       = j_q;
  assign bus.K       = k_q;
  assign bus.rd_data = rd_q;
  assign bus.done    = (state == RESP);
  assign bus.done_id = id_q;

`ifdef JK_CMD_VERIFY_EN
  logic [1:0]       op_q;
  logic [NBITS-1:0] mask_q, q_pre, f_val, expected;
  logic             err_q;

  always_comb begin
    f_val = q_pre;
    case (op_q)
      2'b00: f_val = q_pre;
      2'b01: f_val = '0;
      2'b10: f_val = '1;
      2'b11: f_val = ~q_pre;
      default: f_val = q_pre;
    endcase
    expected = (q_pre & ~mask_q) | (mask_q & f_val);
  end

  // q_pre is taken before the bank updates at the end of ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      mask_q <= '0;
      q_pre  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        op_q   <= win_op;
        mask_q <= win_mask;
      end
      if (state == ISSUE)
        q_pre <= bus.q_in;
      if (state == CAPTURE)
        err_q <= (bus.q_in != expected);
    end
  end

  assign bus.err = err_q && (state == RESP);
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Scoreboard bench for jk_cmd_arbiter with a behavioural JK bank on q_in.
// Expected err in the fault test depends on whether JK_CMD_VERIFY_EN is defined.
module tb_jk_cmd_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 8;
`ifdef JK_CMD_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jk_cmd_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS)) bus();

  jk_cmd_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0] bankQ    = 8'h00;
  logic       faultArm = 1'b0;
  assign bus.q_in = faultArm ? 8'h00 : bankQ;

  // External JK bank: set, reset, toggle or hold per bit.
  always @(posedge clk)
    bankQ <= (bus.J & ~bankQ) | (~bus.K & bankQ);

  typedef struct {
    int         id;
    logic [7:0] rd;
    logic       err;
  } resp_t;

  typedef struct {
    int         id;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] rd;
    logic       err;
  } vec_t;

  resp_t      sbQ[$];
  vec_t       vecQ[$];
  int         pendLeft[NREQ];
  logic [1:0] pendOp[NREQ];
  logic [7:0] pendMask[NREQ];
  int         checks = 0;
  int         errors = 0;
  bit         spacingOn = 1'b0;
  bit         haveLast = 1'b0;
  time        lastDone = 0;
  resp_t      monR;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void setReq(input int id, input logic [1:0] op, input logic [7:0] mask, input int n);
    pendOp[id]   = op;
    pendMask[id] = mask;
    pendLeft[id] = n;
  endfunction

  function automatic void addVec(input int id, input logic [7:0] j, input logic [7:0] k,
                                 input logic [7:0] rd, input logic e);
    vec_t v;
    v.id = id; v.j = j; v.k = k; v.rd = rd; v.err = e;
    vecQ.push_back(v);
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checkOutput("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.done === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          monR = sbQ.pop_front();
          checkOutput("done_id", 32'(bus.done_id), 32'(monR.id));
          checkOutput("rd_data", 32'(bus.rd_data), 32'(monR.rd));
          checkOutput("err", 32'(bus.err), 32'(monR.err));
        end
        if (spacingOn) begin
          if (haveLast)
            checkOutput("done_spacing", 32'($time - lastDone), 32'd40);
          lastDone = $time;
          haveLast = 1'b1;
        end
      end
    end
  end

  // Raises every pending requester and walks the expected grant order in vecQ.
  task automatic applyStimulus();
    int   budget;
    vec_t v;
    for (int i = 0; i < NREQ; i++) begin
      if (pendLeft[i] > 0) begin
        bus.req_valid[i]           = 1'b1;
        bus.req_op[2*i +: 2]       = pendOp[i];
        bus.req_mask[8*i +: 8]     = pendMask[i];
      end
    end
    #1;
    while (vecQ.size() > 0) begin
      budget = 0;
      while (bus.req_ready == '0 && budget < 20) begin
        @(posedge clk); #1;
        budget++;
      end
      if (bus.req_ready == '0) begin
        checkOutput("grant_timeout", 32'd0, 32'd1);
        bus.req_valid = '0;
        vecQ.delete();
        return;
      end
      v = vecQ.pop_front();
      checkOutput("grant", 32'(bus.req_ready), 32'd1 << v.id);
      sbQ.push_back('{v.id, v.rd, v.err});
      @(posedge clk); #1;
      pendLeft[v.id]--;
      if (pendLeft[v.id] <= 0)
        bus.req_valid[v.id] = 1'b0;
      checkOutput("J", 32'(bus.J), 32'(v.j));
      checkOutput("K", 32'(bus.K), 32'(v.k));
    end
  endtask

  task automatic drain();
    int b = 0;
    while (sbQ.size() > 0 && b < 20) begin
      @(posedge clk);
      b++;
    end
    if (sbQ.size() > 0) begin
      checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int b;
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.req_op    = '0;
    bus.req_mask  = '0;
    for (int i = 0; i < NREQ; i++) pendLeft[i] = 0;
    #12;
    checkOutput("rst_J", 32'(bus.J), 32'h0);
    checkOutput("rst_K", 32'(bus.K), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_err", 32'(bus.err), 32'h0);
    checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = '0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] set low nibble from requester 0");
    setReq(0, 2'b10, 8'h0F, 1);
    addVec(0, 8'h0F, 8'h00, 8'h0F, 1'b0);
    applyStimulus(); drain();

    $display("[TB] toggle all from requester 1");
    setReq(1, 2'b11, 8'hFF, 1);
    addVec(1, 8'hFF, 8'hFF, 8'hF0, 1'b0);
    applyStimulus(); drain();
    checkOutput("rd_hold", 32'(bus.rd_data), 32'hF0);

    $display("[TB] requesters 0 and 2 together");
    doReset();
    setReq(0, 2'b01, 8'h30, 1);
    setReq(2, 2'b00, 8'hFF, 1);
    addVec(0, 8'h00, 8'h30, 8'hC0, 1'b0);
    addVec(2, 8'h00, 8'h00, 8'hC0, 1'b0);
    applyStimulus(); drain();

    $display("[TB] all four requesters, two commands each");
    doReset();
    setReq(0, 2'b10, 8'h01, 2);
    setReq(1, 2'b11, 8'h03, 2);
    setReq(2, 2'b01, 8'h02, 2);
    setReq(3, 2'b11, 8'h80, 2);
    addVec(0, 8'h01, 8'h00, 8'hC1, 1'b0);
    addVec(1, 8'h03, 8'h03, 8'hC2, 1'b0);
    addVec(2, 8'h00, 8'h02, 8'hC0, 1'b0);
    addVec(3, 8'h80, 8'h80, 8'h40, 1'b0);
    addVec(0, 8'h01, 8'h00, 8'h41, 1'b0);
    addVec(1, 8'h03, 8'h03, 8'h42, 1'b0);
    addVec(2, 8'h00, 8'h02, 8'h40, 1'b0);
    addVec(3, 8'h80, 8'h80, 8'hC0, 1'b0);
    haveLast  = 1'b0;
    spacingOn = 1'b1;
    applyStimulus(); drain();
    spacingOn = 1'b0;

    $display("[TB] reset during ISSUE");
    doReset();
    bus.req_valid[2]      = 1'b1;
    bus.req_op[5:4]       = 2'b10;
    bus.req_mask[23:16]   = 8'hFF;
    #1;
    b = 0;
    while (bus.req_ready == '0 && b < 20) begin
      @(posedge clk); #1;
      b++;
    end
    checkOutput("abort_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    checkOutput("abort_J_issue", 32'(bus.J), 32'hFF);
    checkOutput("abort_K_issue", 32'(bus.K), 32'h00);
    bus.req_valid[2] = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_J", 32'(bus.J), 32'h0);
    checkOutput("abort_K", 32'(bus.K), 32'h0);
    checkOutput("abort_done", 32'(bus.done), 32'h0);
    checkOutput("abort_rd_data", 32'(bus.rd_data), 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    setReq(0, 2'b00, 8'h00, 1);
    setReq(3, 2'b01, 8'hC0, 1);
    addVec(0, 8'h00, 8'h00, 8'hC0, 1'b0);
    addVec(3, 8'h00, 8'hC0, 8'h00, 1'b0);
    applyStimulus(); drain();

    $display("[TB] readback fault");
    faultArm = 1'b1;
    setReq(1, 2'b10, 8'h01, 1);
    addVec(1, 8'h01, 8'h00, 8'h00, VERIFY);
    applyStimulus(); drain();
    faultArm = 1'b0;
    setReq(2, 2'b00, 8'hFF, 1);
    addVec(2, 8'h00, 8'h00, 8'h01, 1'b0);
    applyStimulus(); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/jk_cmd_arbiter.md
Name: jk_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external bank of NBITS JK flip-flops between NREQ requesters.
- Each requester submits a masked command: hold/read, reset, set or toggle.
- The block grants one requester, drives J/K for exactly one clock, then captures the bank's Q outputs and returns them with a done pulse.
- It sits between software-visible request sources and the JK flip-flop bank.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, width of the JK bank driven

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester command valid
- req_ready  output  NREQ  one-hot grant; high only for the winner, only in IDLE
- req_op  input  2*NREQ  op for requester i at [2i+1:2i]: 00 hold/read, 01 reset, 10 set, 11 toggle
- req_mask  input  NBITS*NREQ  bit-select for requester i at [NBITS*i +: NBITS]
- J  output  NBITS  J drive to bank, registered
- K  output  NBITS  K drive to bank, registered
- q_in  input  NBITS  Q outputs of bank
- done  output  1  one-cycle completion pulse
- done_id  output  $clog2(NREQ)  index of completed requester, valid with done
- rd_data  output  NBITS  bank Q captured after the command, held until next capture
- err  output  1  verify mismatch, valid with done (see Optional Feature)

Behaviour:
- States: IDLE, ISSUE, CAPTURE, RESP. The FSM is a fixed sequence with no stalls, so throughput is one command per 4 cycles.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - req_ready[winner] is combinationally high.
  - At the posedge, latch op, mask and id, then go to ISSUE.
  - If no valid request, stay in IDLE with req_ready = 0.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high at a posedge.
  - A requester holds valid, op and mask stable until granted.
  - Deasserting valid before the grant withdraws the request; this is legal.
- rr_ptr update: on each grant, rr_ptr <= winner+1, wrapping from NREQ-1 to 0.
- ISSUE (J/K registered, so they are high exactly during this cycle):
  - Masked bits: op 00 gives J=0,K=0; op 01 gives J=0,K=1; op 10 gives J=1,K=0; op 11 gives J=1,K=1.
  - Unmasked bits: J=K=0 always.
  - The bank samples J/K at the posedge ending ISSUE.
  - J/K return to 0 in CAPTURE.
- CAPTURE: rd_data <= q_in at the posedge ending this cycle.
- RESP:
  - done=1, done_id=latched id, rd_data valid.
  - Next state IDLE.
  - done is low in every other state.
- Latency: grant edge at posedge t; J/K active in cycle t..t+1; rd_data/done valid in cycle t+2..t+3.
- Mask all-zero: accepted; J=K=0 in ISSUE; completes normally with a pure read.
- Reset (asynchronous, any state, including mid-command):
  - Immediately: state=IDLE, J=K=0, done=0, err=0, rd_data=0, rr_ptr=0, req_ready=0 while reset is high.
  - An aborted command produces no done.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait; no starvation (each waits at most NREQ-1 commands).

Optional Feature:
- Macro: JK_CMD_VERIFY_EN.
- Defined:
  - In ISSUE, the block snapshots q_in as q_pre.
  - In CAPTURE, it computes expected = (q_pre & ~mask) | (mask & f(op)), where f is: hold → q_pre, reset → 0, set → all ones, toggle → ~q_pre.
  - err is registered high in RESP if q_in != expected.
- Not defined: no q_pre register or comparator; err is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Reset, then requester 0 issues op=10, mask=8'h0F → J=8'h0F, K=8'h00 for one cycle; done with done_id=0, rd_data=8'h0F 3 cycles after the grant.
- From 8'h0F, requester 1 issues op=11, mask=8'hFF → J=K=8'hFF for one cycle; rd_data=8'hF0, err=0.
- Requesters 0 and 2 assert together after reset (rr_ptr=0) → 0 is granted first, then 2; done_id sequence 0,2; req_ready is never two-hot.
- All four requesters hold valid for 8 commands → grant order 0,1,2,3,0,1,2,3; each done is 4 cycles apart.
- Assert reset during ISSUE of an op=10, mask=8'hFF command → J=K=0 immediately, no done, state IDLE, rr_ptr=0; the next request is granted normally.
- JK_CMD_VERIFY_EN: the bench model forces q_in=8'h00 after op=10, mask=8'h01 → err=1 with done; without the macro, err=0 always.
